board_ctrl: RTL

Owner and sequencer of the 64-square board register file, replacing ad-hoc direct writes to the board array. Three sources share the single write path under fixed priority: new-game initialization, atomic piece moves (source to destination), and single-square writes such as pawn promotion. The block exports the flattened 256-bit board to `chess_logic` and `display_interface` and sits in `chess_top` on `game_logic_clk`.

---
 rtl/chess_pkg.sv | 40 ++++
 rtl/board_init_rom.sv | 39 +++
 rtl/board_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece/colour codes, controller state encoding and
// square-address field helpers. Squares are encoded {row[2:0], col[2:0]}.
package chess_pkg;

    localparam int SQ_COUNT = 64;
    localparam int SQ_W     = 6;
    localparam int PIECE_W  = 4;
    localparam int BOARD_W  = SQ_COUNT * PIECE_W;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_MV_DST = 2'd2,
        ST_MV_SRC = 2'd3
    } state_t;

    function automatic logic [2:0] sq_row(input logic [SQ_W-1:0] sq);
        return sq[5:3];
    endfunction

    function automatic logic [2:0] sq_col(input logic [SQ_W-1:0] sq);
        return sq[2:0];
    endfunction

    function automatic logic [PIECE_W-1:0] make_piece(input logic color, input logic [2:0] kind);
        return {color, kind};
    endfunction

endpackage

// File: rtl/board_init_rom.sv
// Combinational starting-position table: square index -> initial piece code.
// Black occupies rows 0-1, white rows 6-7, rows 2-5 are empty.
module board_init_rom
    import chess_pkg::*;
(
    input  logic [SQ_W-1:0]    idx,
    output logic [PIECE_W-1:0] piece
);

    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] back_rank;

    assign row = sq_row(idx);
    assign col = sq_col(idx);

    always_comb begin
        back_rank = PIECE_KING;
        case (col)
            3'd0, 3'd7: back_rank = PIECE_ROOK;
            3'd1, 3'd6: back_rank = PIECE_KNIGHT;
            3'd2, 3'd5: back_rank = PIECE_BISHOP;
            3'd3:       back_rank = PIECE_QUEEN;
            default:    back_rank = PIECE_KING;
        endcase
    end

    always_comb begin
        piece = '0;
        case (row)
            3'd0:    piece = make_piece(COLOR_BLACK, back_rank);
            3'd1:    piece = make_piece(COLOR_BLACK, PIECE_PAWN);
            3'd6:    piece = make_piece(COLOR_WHITE, PIECE_PAWN);
            3'd7:    piece = make_piece(COLOR_WHITE, back_rank);
            default: piece = '0;
        endcase
    end

endmodule

// File: rtl/board_ctrl.sv
// Board register file owner: arbitrates new-game init > move > single write onto
// one square write port. Optional capture log enabled by BOARD_CAPTURE_LOG_EN.
module board_ctrl
    import chess_pkg::*;
#(
    parameter int INIT_ON_RESET = 1
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               INIT_REQ,
    input  logic               MV_VALID,
    output logic               MV_READY,
    input  logic [SQ_W-1:0]    MV_SRC,
    input  logic [SQ_W-1:0]    MV_DST,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic [SQ_W-1:0]    WR_ADDR,
    input  logic [PIECE_W-1:0] WR_PIECE,
    output logic [BOARD_W-1:0] BOARD,
    output logic               BUSY,
    output logic               DONE
`ifdef BOARD_CAPTURE_LOG_EN
    ,
    output logic [3:0]         CAPT_PIECE,
    output logic [3:0]         CAPT_CNT_W,
    output logic [3:0]         CAPT_CNT_B
`endif
);

    state_t               state_reg;
    state_t               state_next;
    logic [SQ_W-1:0]      idx_reg;
    logic [SQ_W-1:0]      src_reg;
    logic [SQ_W-1:0]      dst_reg;
    logic [PIECE_W-1:0]   piece_reg;
    logic                 done_reg;
    logic [PIECE_W-1:0]   rom_piece;

    logic                 init_go;
    logic                 mv_accept;
    logic                 wr_accept;
    logic                 sq_we;
    logic [SQ_W-1:0]      sq_waddr;
    logic [PIECE_W-1:0]   sq_wdata;

    board_init_rom u_rom (
        .idx   (idx_reg),
        .piece (rom_piece)
    );

    assign init_go   = (state_reg == ST_IDLE) && INIT_REQ;
    assign mv_accept = MV_READY && MV_VALID;
    assign wr_accept = WR_READY && WR_VALID;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (INIT_REQ)
                    state_next = ST_INIT;
                else if (MV_VALID)
                    state_next = ST_MV_DST;
            end
            ST_INIT:   if (idx_reg == 6'd63) state_next = ST_IDLE;
            ST_MV_DST: state_next = ST_MV_SRC;
            ST_MV_SRC: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Ready is forced low during reset even when the reset state is IDLE.
    always_comb begin
        BUSY     = (state_reg != ST_IDLE);
        MV_READY = !RESET && (state_reg == ST_IDLE) && !INIT_REQ;
        WR_READY = !RESET && (state_reg == ST_IDLE) && !INIT_REQ && !MV_VALID;
    end

    // Single shared square write port; a move onto itself skips the clear.
    always_comb begin
        sq_we    = 1'b0;
        sq_waddr = '0;
        sq_wdata = '0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_accept) begin
                    sq_we    = 1'b1;
                    sq_waddr = WR_ADDR;
                    sq_wdata = WR_PIECE;
                end
            end
            ST_INIT: begin
                sq_we    = 1'b1;
                sq_waddr = idx_reg;
                sq_wdata = rom_piece;
            end
            ST_MV_DST: begin
                sq_we    = 1'b1;
                sq_waddr = dst_reg;
                sq_wdata = piece_reg;
            end
            ST_MV_SRC: begin
                sq_we    = (src_reg != dst_reg);
                sq_waddr = src_reg;
                sq_wdata = '0;
            end
            default: sq_we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_reg   <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            piece_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= ((state_reg == ST_INIT) && (idx_reg == 6'd63)) ||
                        (state_reg == ST_MV_SRC) || wr_accept;
            if (init_go)
                idx_reg <= '0;
            else if (state_reg == ST_INIT)
                idx_reg <= idx_reg + 6'd1;
            if (mv_accept) begin
                src_reg   <= MV_SRC;
                dst_reg   <= MV_DST;
                piece_reg <= BOARD[{MV_SRC, 2'b00} +: PIECE_W];
            end
        end
    end

    assign DONE = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SQ_COUNT; gi++) begin : g_sq
            logic [PIECE_W-1:0] sq_reg;
            always_ff @(posedge CLK) begin
                if (RESET)
                    sq_reg <= '0;
                else if (sq_we && (sq_waddr == SQ_W'(gi)))
                    sq_reg <= sq_wdata;
            end
            assign BOARD[gi*PIECE_W +: PIECE_W] = sq_reg;
        end
    endgenerate

`ifdef BOARD_CAPTURE_LOG_EN
    logic [3:0]         capt_piece_reg;
    logic [3:0]         capt_cnt_w_reg;
    logic [3:0]         capt_cnt_b_reg;
    logic [PIECE_W-1:0] dst_old;

    assign dst_old = BOARD[{dst_reg, 2'b00} +: PIECE_W];

    // Sampled before the MV_DST write lands, so dst_old is the victim.
    always_ff @(posedge CLK) begin
        if (RESET || init_go) begin
            capt_piece_reg <= '0;
            capt_cnt_w_reg <= '0;
            capt_cnt_b_reg <= '0;
        end else if ((state_reg == ST_MV_DST) && (dst_old[2:0] != PIECE_NONE)) begin
            capt_piece_reg <= dst_old;
            if (dst_old[3] == COLOR_BLACK) begin
                if (capt_cnt_b_reg != 4'hF)
                    capt_cnt_b_reg <= capt_cnt_b_reg + 4'd1;
            end else begin
                if (capt_cnt_w_reg != 4'hF)
                    capt_cnt_w_reg <= capt_cnt_w_reg + 4'd1;
            end
        end
    end

    assign CAPT_PIECE = capt_piece_reg;
    assign CAPT_CNT_W = capt_cnt_w_reg;
    assign CAPT_CNT_B = capt_cnt_b_reg;
`endif

endmodule
